// File: rtl/hash_stream_io_if.sv
// Bundle of stream, core and status signals for hash_stream_io.
// Latency: none; this is wiring only.
// Backpressure: in_valid/in_ready on input and out_valid/out_ready on output.
interface hash_stream_io_if #(
    parameter int Y = 256,
    parameter int L = 256,
    parameter int W = 8
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [Y-1:0] msg;
    logic         core_start;
    logic [L-1:0] core_digest;
    logic         core_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         err;
    logic [15:0]  lat_cnt;

    // Block side: accepts the message stream, drives the core, emits the digest.
    modport master (
        input  in_data, in_valid, core_digest, core_ready, out_ready,
        output in_ready, msg, core_start, out_data, out_valid, err, lat_cnt
    );

    // Environment side: source, hash core and sink.
    modport slave (
        output in_data, in_valid, core_digest, core_ready, out_ready,
        input  in_ready, msg, core_start, out_data, out_valid, err, lat_cnt
    );
endinterface

// File: rtl/hash_stream_io.sv
// Streams a Y-bit message in as W-bit beats, kicks a parallel hash core, streams the L-bit digest out.
// Latency: Y/W load beats, START_HOLD start cycles, core wait (<=TIMEOUT), then L/W unload beats.
// Backpressure: in_ready only in LOAD; UNLOAD holds out_data while out_ready is low. Macro HASH_IO_LAT_EN builds lat_cnt.
module hash_stream_io #(
    parameter int Y          = 256,
    parameter int L          = 256,
    parameter int W          = 8,
    parameter int START_HOLD = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    hash_stream_io_if.master  io_bus
);

    localparam int NB_IN  = Y / W;
    localparam int NB_OUT = L / W;
    localparam int CW_IN  = (NB_IN > 1) ? $clog2(NB_IN) : 1;
    localparam int CW_OUT = (NB_OUT > 1) ? $clog2(NB_OUT) : 1;
    localparam int SW     = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam int TW     = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    state_t              r_state;
    logic [CW_IN-1:0]    r_in_cnt;
    logic [CW_OUT-1:0]   r_out_cnt;
    logic [SW-1:0]       r_start_cnt;
    logic [TW-1:0]       r_wait_cnt;
    logic [Y-1:0]        r_msg;
    logic [L-1:0]        r_shift;
    logic                r_in_ready;
    logic                r_core_start;
    logic                r_out_valid;
    logic                r_err;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_in_last;
    logic                w_out_last;
    logic                w_start_last;
    logic                w_wait_last;
    logic                w_capture;
    logic                w_abort;
    logic                w_load_done;
    logic [Y-1:0]        w_msg_next;

    // r_in_ready is only ever high in LOAD, so beats offered elsewhere are never taken.
    assign w_in_fire    = io_bus.in_valid & r_in_ready;
    assign w_out_fire   = r_out_valid & io_bus.out_ready;
    assign w_in_last    = (r_in_cnt == CW_IN'(NB_IN - 1));
    assign w_out_last   = (r_out_cnt == CW_OUT'(NB_OUT - 1));
    assign w_start_last = (r_start_cnt == SW'(START_HOLD - 1));
    assign w_wait_last  = (r_wait_cnt == TW'(TIMEOUT - 1));
    // core_ready is looked at only in WAIT; a ready seen on the last allowed cycle still wins over the timeout.
    assign w_capture    = (r_state == S_WAIT) & io_bus.core_ready;
    assign w_abort      = (r_state == S_WAIT) & ~io_bus.core_ready & w_wait_last;
    assign w_load_done  = (r_state == S_LOAD) & w_in_fire & w_in_last;

    // Place the incoming beat into its MSB-first slot of the message register.
    always_comb begin
        w_msg_next = r_msg;
        for (int k = 0; k < NB_IN; k++) begin
            if (r_in_cnt == CW_IN'(k)) begin
                w_msg_next[Y-1-k*W -: W] = io_bus.in_data;
            end
        end
    end

    // Main LOAD/START/WAIT/UNLOAD sequencer with all handshake outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_LOAD;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_start_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_msg        <= '0;
            r_shift      <= '0;
            r_in_ready   <= 1'b1;
            r_core_start <= 1'b0;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_msg <= w_msg_next;
                        if (w_in_last) begin
                            r_in_cnt     <= '0;
                            r_in_ready   <= 1'b0;
                            r_core_start <= 1'b1;
                            r_start_cnt  <= '0;
                            r_state      <= S_START;
                        end else begin
                            r_in_cnt <= r_in_cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (w_start_last) begin
                        r_core_start <= 1'b0;
                        r_wait_cnt   <= '0;
                        r_state      <= S_WAIT;
                    end else begin
                        r_start_cnt <= r_start_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_capture) begin
                        r_shift     <= io_bus.core_digest;
                        r_out_cnt   <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_UNLOAD;
                    end else if (w_abort) begin
                        // Core never answered: flag it and drop the message, nothing is emitted.
                        r_err      <= 1'b1;
                        r_msg      <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_LOAD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (w_out_fire) begin
                        r_shift <= r_shift << W;
                        if (w_out_last) begin
                            // Straight back to LOAD so the next message can start on the following edge.
                            r_out_cnt   <= '0;
                            r_out_valid <= 1'b0;
                            r_msg       <= '0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_LOAD;
                        end else begin
                            r_out_cnt <= r_out_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

`ifdef HASH_IO_LAT_EN
    logic [15:0] r_lat;
    logic [15:0] r_lat_cnt;

    // Latency counter: 0 on the first START cycle, +1 per cycle through START/WAIT, sticks at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lat     <= '0;
            r_lat_cnt <= '0;
        end else begin
            if (w_load_done) begin
                r_lat <= '0;
            end else if (((r_state == S_START) || (r_state == S_WAIT)) && (r_lat != 16'hFFFF)) begin
                r_lat <= r_lat + 16'd1;
            end
            if (w_capture) begin
                r_lat_cnt <= r_lat;
            end
        end
    end

    assign io_bus.lat_cnt = r_lat_cnt;
`else
    assign io_bus.lat_cnt = 16'h0000;
`endif

    assign io_bus.in_ready   = r_in_ready;
    assign io_bus.msg        = r_msg;
    assign io_bus.core_start = r_core_start;
    assign io_bus.out_data   = r_shift[L-1 -: W];
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.err        = r_err;

endmodule

// File: tb/tb_hash_stream_io.sv
// Bench for hash_stream_io: table of hashes through a core model plus reset/timeout/backpressure sequences.
// Expected digest beats are queued when the core model answers and compared as the DUT emits them.
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_hash_stream_io;

    localparam int Y  = 64;
    localparam int L  = 64;
    localparam int W  = 8;
    localparam int SH = 2;
    localparam int TO = 32;
`ifdef HASH_IO_LAT_EN
    localparam bit LAT_ON = 1'b1;
`else
    localparam bit LAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hash_stream_io_if #(.Y(Y), .L(L), .W(W)) bus ();

    hash_stream_io #(
        .Y(Y), .L(L), .W(W), .START_HOLD(SH), .TIMEOUT(TO)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    typedef struct {
        logic [63:0] msg;
        logic [63:0] dig;
        int          delay;
        logic [3:0]  pat;
    } vec_t;

    vec_t tbl [4];

    int n_cmp = 0;
    int n_bad = 0;

    int          cyc = 0;
    logic [7:0]  in_q [$];
    logic [7:0]  exp_q [$];
    bit          hold_valid = 1'b0;
    int          n_acc = 0;
    int          upos = 0;
    logic [3:0]  pat = 4'b1111;
    bit          seen_start = 1'b0;
    bit          fired = 1'b0;
    bit          force_rdy = 1'b0;
    bit          never = 1'b0;
    int          t0 = 0;
    int          delay = 0;
    int          cs_cnt = 0;
    int          first_ov = -1;
    int          err_cyc = -1;
    int          n_out = 0;
    int          bad_inrdy = 0;
    logic [63:0] dig = '0;
    logic [63:0] msg_t0 = '0;
    logic [63:0] msg_ov = '0;
    logic [7:0]  tmp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_dig(input logic [63:0] d);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[63-8*i -: 8]);
    endtask

    // One clock: drive source/sink, score the transfers of the coming edge, then run the core model.
    task automatic step();
        if (in_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = in_q[0];
        end else begin
            bus.in_valid = hold_valid;
            bus.in_data  = 8'h5A;
        end
        bus.out_ready = pat[3 - (upos % 4)];
        if (bus.in_valid && bus.in_ready) begin
            n_acc++;
            if (in_q.size() > 0) tmp = in_q.pop_front();
        end
        if (bus.in_ready && (bus.core_start || bus.out_valid)) bad_inrdy++;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_out: out_valid with data %h, expected no beat", bus.out_data);
            end else if (bus.out_ready) begin
                chk("out_beat", {56'h0, bus.out_data}, {56'h0, exp_q[0]});
                tmp = exp_q.pop_front();
                n_out++;
            end else begin
                chk("out_hold", {56'h0, bus.out_data}, {56'h0, exp_q[0]});
            end
            upos++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus.core_start) cs_cnt++;
        if (!force_rdy && bus.core_ready) bus.core_ready = 1'b0;
        if (force_rdy && bus.out_valid) begin
            bus.core_ready = 1'b0;
            force_rdy      = 1'b0;
        end
        if (bus.core_start && !seen_start) begin
            seen_start = 1'b1;
            t0         = cyc;
            msg_t0     = bus.msg;
            if (force_rdy) begin
                bus.core_ready  = 1'b1;
                bus.core_digest = dig;
                push_dig(dig);
                fired = 1'b1;
            end
        end
        if (seen_start && !fired && !never && cyc == t0 + delay) begin
            bus.core_ready  = 1'b1;
            bus.core_digest = dig;
            push_dig(dig);
            fired = 1'b1;
        end
        if (bus.out_valid && first_ov < 0) begin
            first_ov = cyc;
            msg_ov   = bus.msg;
        end
        if (bus.err && err_cyc < 0) err_cyc = cyc;
    endtask

    task automatic init_hash(input logic [63:0] d, input int dl, input logic [3:0] p);
        seen_start = 1'b0;
        fired      = 1'b0;
        never      = 1'b0;
        cs_cnt     = 0;
        first_ov   = -1;
        err_cyc    = -1;
        n_out      = 0;
        upos       = 0;
        dig        = d;
        delay      = dl;
        pat        = p;
    endtask

    task automatic push_msg(input logic [63:0] m);
        for (int k = 0; k < 8; k++) in_q.push_back(m[63-8*k -: 8]);
    endtask

    // Full hash through the core model; force=1 holds core_ready high from the first START cycle.
    task automatic run_hash(input logic [63:0] m, input logic [63:0] d, input int dl,
                            input logic [3:0] p, input bit frc, input bit push_in, input logic e_err);
        int guard;
        init_hash(d, dl, p);
        force_rdy = frc;
        if (push_in) push_msg(m);
        guard = 0;
        while (n_out < 8 && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL hash_budget: %0d beats out after %0d cycles, expected 8", n_out, guard);
        end
        chk("msg_first_start", msg_t0, m);
        chk("core_start_len", 64'(cs_cnt), 64'(SH));
        chk("first_out_cycle", 64'(first_ov), 64'(t0 + dl + 1));
        chk("msg_stable", msg_ov, m);
        chk("lat_cnt", {48'h0, bus.lat_cnt}, LAT_ON ? 64'(dl) : 64'h0);
        chk("out_valid_done", {63'h0, bus.out_valid}, 64'h0);
        chk("in_ready_done", {63'h0, bus.in_ready}, 64'h1);
        chk("msg_cleared", bus.msg, 64'h0);
        chk("err_after_hash", {63'h0, bus.err}, {63'h0, e_err});
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.core_ready = 1'b0;
        force_rdy      = 1'b0;
        rst            = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int guard;
        tbl[0] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 10, 4'b1001};
        tbl[1] = '{64'h1122334455667788, 64'hA5A55A5A0FF0C33C, 2,  4'b1111};
        tbl[2] = '{64'hFFFF0000AAAA5555, 64'h0102040810204080, 33, 4'b0110};
        tbl[3] = '{64'h0F0F0F0FF0F0F0F0, 64'h13579BDF2468ACE0, 7,  4'b0101};

        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.core_digest = '0;
        bus.core_ready  = 1'b0;
        bus.out_ready   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();
        chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rst_core_start", {63'h0, bus.core_start}, 64'h0);
        chk("rst_err", {63'h0, bus.err}, 64'h0);
        chk("rst_lat_cnt", {48'h0, bus.lat_cnt}, 64'h0);
        chk("rst_msg", bus.msg, 64'h0);
        chk("rst_out_data", {56'h0, bus.out_data}, 64'h0);

        // Table: back-to-back hashes with various core delays and sink patterns.
        for (int i = 0; i < 4; i++) begin
            run_hash(tbl[i].msg, tbl[i].dig, tbl[i].delay, tbl[i].pat, 1'b0, 1'b1, 1'b0);
        end

        // in_valid held high throughout, core_ready high during START: no extra beats, capture in first WAIT cycle.
        n_acc     = 0;
        bad_inrdy = 0;
        hold_valid = 1'b1;
        push_msg(64'hDEADBEEF00C0FFEE);
        push_msg(tbl[3].msg);
        run_hash(64'hDEADBEEF00C0FFEE, 64'h0F1E2D3C4B5A6978, SH, 4'b1111, 1'b1, 1'b0, 1'b0);
        chk("accepted_beats", 64'(n_acc), 64'd8);
        chk("in_ready_outside_load", 64'(bad_inrdy), 64'h0);
        hold_valid = 1'b0;
        run_hash(tbl[3].msg, tbl[3].dig, tbl[3].delay, tbl[3].pat, 1'b0, 1'b0, 1'b0);

        // Core never answers: timeout after TO WAIT cycles, message dropped, err sticky.
        init_hash(64'h0, 0, 4'b1111);
        never = 1'b1;
        push_msg(64'hC0C1C2C3C4C5C6C7);
        guard = 0;
        while (err_cyc < 0 && guard < 200) begin
            step();
            guard++;
        end
        chk("timeout_cycle", 64'(err_cyc), 64'(t0 + SH + TO));
        chk("timeout_in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("timeout_msg", bus.msg, 64'h0);
        chk("timeout_err", {63'h0, bus.err}, 64'h1);
        repeat (5) step();
        run_hash(tbl[0].msg, tbl[0].dig, tbl[0].delay, 4'b1111, 1'b0, 1'b1, 1'b1);

        // Reset after 3 accepted beats: partial message dropped, fresh load works.
        init_hash(64'h0, 0, 4'b1111);
        n_acc = 0;
        push_msg(64'h99AABBCCDDEEFF00);
        guard = 0;
        while (n_acc < 3 && guard < 50) begin
            step();
            guard++;
        end
        do_reset();
        chk("midload_msg", bus.msg, 64'h0);
        chk("midload_err", {63'h0, bus.err}, 64'h0);
        chk("midload_in_ready", {63'h0, bus.in_ready}, 64'h1);
        run_hash(tbl[1].msg, tbl[1].dig, tbl[1].delay, tbl[1].pat, 1'b0, 1'b1, 1'b0);

        // Reset in WAIT: no timeout flag, no output afterwards.
        init_hash(tbl[2].dig, 0, 4'b1111);
        never = 1'b1;
        push_msg(tbl[2].msg);
        guard = 0;
        while (!(seen_start && cyc >= t0 + 4) && guard < 100) begin
            step();
            guard++;
        end
        do_reset();
        repeat (40) step();
        chk("midwait_err", {63'h0, bus.err}, 64'h0);
        chk("midwait_core_start", {63'h0, bus.core_start}, 64'h0);

        // Reset after 3 output beats: remaining beats never appear.
        init_hash(tbl[0].dig, 5, 4'b1111);
        push_msg(tbl[0].msg);
        guard = 0;
        while (n_out < 3 && guard < 100) begin
            step();
            guard++;
        end
        chk("midunload_beats", 64'(n_out), 64'd3);
        do_reset();
        chk("midunload_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("midunload_msg", bus.msg, 64'h0);
        repeat (20) step();
        chk("midunload_in_ready", {63'h0, bus.in_ready}, 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
